// File: rtl/irf_pkg.sv
// rtl/irf_pkg.sv - shared sizes, reset value and output-stage state encoding for the register-file read port
package irf_pkg;

  localparam int          IRF_DW      = 8;
  localparam int          IRF_NREG    = 8;
  localparam int          IRF_AW      = 3;
  localparam logic [7:0]  IRF_RST_VAL = 8'h00;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } irf_state_e;

endpackage

// File: rtl/irf_onehot_chk.sv
// rtl/irf_onehot_chk.sv - classifies a write-enable vector as none, exactly one-hot, or (implicitly) multi-hot
module irf_onehot_chk #(
  parameter int N = 8
) (
  input  logic [N-1:0] we,
  output logic         one_hot,
  output logic         none
);

  assign none    = (we == '0);
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign one_hot = !none && ((we & (we - N'(1))) == '0);

endmodule

// File: rtl/irf_read_port.sv
// rtl/irf_read_port.sv - 8-entry register file with one-hot write and a single-entry registered read stage;
// define IRF_READ_BYPASS_EN to forward a same-cycle single-hot write to the read result.
module irf_read_port
  import irf_pkg::*;
#(
  parameter int              DW      = IRF_DW,
  parameter int              NREG    = IRF_NREG,
  parameter logic [DW-1:0]   RST_VAL = DW'(IRF_RST_VAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREG-1:0]   we,
  input  logic [DW-1:0]     wd,
  input  logic              rd_req,
  input  logic [IRF_AW-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  input  logic              rd_ack,
  output logic              err_multi
);

  logic [DW-1:0] regs [NREG];
  logic          one_hot;
  logic          none;
  logic          fwd;
  logic          accept;
  logic [DW-1:0] rd_next;
  irf_state_e    state_q;
  irf_state_e    state_d;

  irf_onehot_chk #(.N(NREG)) u_onehot_chk (
    .we      (we),
    .one_hot (one_hot),
    .none    (none)
  );

  // Multi-hot enables are treated as a fault: nothing is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
      err_multi <= 1'b0;
    end else begin
      if (one_hot) begin
        for (int i = 0; i < NREG; i++) begin
          if (we[i]) regs[i] <= wd;
        end
      end
      if (!one_hot && !none) err_multi <= 1'b1;
    end
  end

`ifdef IRF_READ_BYPASS_EN
  assign fwd = one_hot & we[rd_addr];
`else
  assign fwd = 1'b0;
`endif

  assign rd_next  = fwd ? wd : regs[rd_addr];
  assign rd_rdy   = !rst_n || (state_q == ST_EMPTY) || rd_ack;
  assign accept   = rd_req && rd_rdy;
  assign rd_valid = (state_q == ST_FULL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rd_ack && !rd_req) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // rd_data only moves on an accepted read, so a held or drained result keeps its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_irf_read_port.sv
// tb/tb_irf_read_port.sv - directed vector table plus randomized run against a behavioural register-file model
module tb_irf_read_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] we = 8'h00;
  logic [7:0] wd = 8'h00;
  logic       rd_req = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic       rd_rdy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ack = 1'b0;
  logic       err_multi;

  int n_tests = 0;
  int n_fail  = 0;

  irf_read_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wd        (wd),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

`ifdef IRF_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Behavioural model state
  logic [7:0] m_regs [8];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;

  function automatic logic model_rdy(input logic rstn_i, input logic ack_i);
    return !rstn_i || !m_valid || ack_i;
  endfunction

  task automatic model_step(input logic [7:0] we_i, input logic [7:0] wd_i, input logic req_i,
                            input logic [2:0] addr_i, input logic ack_i, input logic rstn_i);
    int  nset;
    logic rdy;
    if (!rstn_i) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_err   = 1'b0;
    end else begin
      nset = $countones(we_i);
      rdy  = !m_valid || ack_i;
      if (req_i && rdy) begin
        m_data  = (BYPASS && nset == 1 && we_i[addr_i]) ? wd_i : m_regs[addr_i];
        m_valid = 1'b1;
      end else if (m_valid && ack_i) begin
        m_valid = 1'b0;
      end
      if (nset == 1) begin
        for (int i = 0; i < 8; i++) if (we_i[i]) m_regs[i] = wd_i;
      end
      if (nset > 1) m_err = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] we;
    logic [7:0] wd;
    logic       req;
    logic [2:0] addr;
    logic       ack;
    logic       rstn;
    logic       exp_rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [24];

  task automatic apply(input logic [7:0] we_i, input logic [7:0] wd_i, input logic req_i,
                       input logic [2:0] addr_i, input logic ack_i, input logic rstn_i);
    we = we_i; wd = wd_i; rd_req = req_i; rd_addr = addr_i; rd_ack = ack_i; rst_n = rstn_i;
  endtask

  initial begin
    logic [7:0] byp40;
    byp40 = BYPASS ? 8'h3C : 8'h00;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[1+i] = '{8'h00, 8'h00, 1'b1, 3'(i), 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{8'h08, 8'hA5, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[11] = '{8'h10, 8'h3C, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, byp40, 1'b0};
    vecs[12] = '{8'h00, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 4; i++)
      vecs[13+i] = '{8'h10, 8'hFF, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[17] = '{8'h00, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[18] = '{8'h06, 8'h77, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[19] = '{8'h00, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[20] = '{8'h00, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[21] = '{8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[22] = '{8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[23] = '{8'h00, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      apply(vecs[k].we, vecs[k].wd, vecs[k].req, vecs[k].addr, vecs[k].ack, vecs[k].rstn);
      #1;
      chk("vec_rd_rdy", k, 8'(rd_rdy), 8'(vecs[k].exp_rdy));
      model_step(vecs[k].we, vecs[k].wd, vecs[k].req, vecs[k].addr, vecs[k].ack, vecs[k].rstn);
      @(posedge clk); #1;
      chk("vec_rd_valid", k, 8'(rd_valid), 8'(vecs[k].exp_valid));
      chk("vec_rd_data", k, rd_data, vecs[k].exp_data);
      chk("vec_err_multi", k, 8'(err_multi), 8'(vecs[k].exp_err));
      @(negedge clk);
    end

    for (int k = 0; k < 400; k++) begin
      logic [7:0] rwe;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      rwe = 8'h00;
      else if (sel < 8) rwe = 8'h01 << $urandom_range(0, 7);
      else              rwe = 8'($urandom);
      apply(rwe, 8'($urandom), 1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 49) != 0));
      #1;
      chk("rnd_rd_rdy", k, 8'(rd_rdy), 8'(model_rdy(rst_n, rd_ack)));
      model_step(we, wd, rd_req, rd_addr, rd_ack, rst_n);
      @(posedge clk); #1;
      chk("rnd_rd_valid", k, 8'(rd_valid), 8'(m_valid));
      chk("rnd_rd_data", k, rd_data, m_data);
      chk("rnd_err_multi", k, 8'(err_multi), 8'(m_err));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irf_read_port.md
IRF_READ_PORT -- requirements
Module: irf_read_port

Interface
REQ-001 Parameter DW, default 8: register width in bits.
REQ-002 Parameter NREG, default 8, fixed: register count; address width 3.
REQ-003 Parameter RST_VAL, default 8'h00: reset contents of every register.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-006 we  input  8  one-hot write enables from the 1-to-8 write demux; bit i selects register i.
REQ-007 wd  input  DW  write data.
REQ-008 rd_req  input  1  read request valid.
REQ-009 rd_addr  input  3  read register index.
REQ-010 rd_rdy  output  1  port can accept a request this cycle.
REQ-011 rd_valid  output  1  rd_data holds a completed read.
REQ-012 rd_data  output  DW  read result.
REQ-013 rd_ack  input  1  downstream consumes rd_data when rd_valid is high.
REQ-014 err_multi  output  1  sticky flag: more than one we bit was seen high.

Function
REQ-015 Storage: NREG x DW registers, written only by we/wd.
REQ-016 Write: exactly one we bit high -> that register loads wd at the next edge.
REQ-017 we all zero -> no write.
REQ-018 Two or more we bits high -> no register written; err_multi set at the next edge and held until reset.
REQ-019 Output stage FSM, two states: EMPTY (rd_valid=0) and FULL (rd_valid=1).
REQ-020 rd_rdy = (state==EMPTY) | rd_ack; combinational; no dependency on rd_req.
REQ-021 Accept when rd_req & rd_rdy; rd_data loads reg[rd_addr] at that edge; state -> FULL; latency 1 cycle.
REQ-022 FULL & rd_ack & !(rd_req) -> EMPTY at next edge; rd_data retains its last value.
REQ-023 FULL & rd_ack & rd_req -> stays FULL with new data (back-to-back, one read per cycle sustained).
REQ-024 FULL & !rd_ack -> rd_data and rd_valid held stable regardless of rd_req or writes.
REQ-025 Read and write to the same address in the same accepting cycle -> see REQ-032/REQ-033.
REQ-026 Writes to a register already captured in rd_data do not alter rd_data.
REQ-027 rd_addr ignored when no request is accepted.

Reset
REQ-028 rst_n low at an edge: all registers -> RST_VAL; state -> EMPTY; rd_valid=0; rd_data=0; err_multi=0.
REQ-029 Reset overrides any simultaneous write or accepted read; a pending FULL result is discarded.
REQ-030 During reset rd_rdy shall be 1; requests in that cycle are dropped.

Configuration
REQ-031 Macro IRF_READ_BYPASS_EN selects same-cycle write forwarding.
REQ-032 Defined: accepted read with valid single-hot write to rd_addr returns wd.
REQ-033 Undefined: such a read returns the pre-write register value.
REQ-034 Multi-hot writes are never forwarded in either configuration.

Structure
REQ-035 Shared package irf_pkg holds DW, NREG, address width, RST_VAL and the EMPTY/FULL state encoding.
REQ-036 One sub-module: irf_onehot_chk (combinational; outputs one_hot and none flags from we), reused by the write path and err_multi logic.
REQ-037 Read mux is an 8:1 selection inside irf_read_port; no separate module.

Verification
REQ-038 Reset, then read each address 0..7 with rd_ack=1 -> rd_data=8'h00 each, one cycle after accept, rd_valid high each cycle.
REQ-039 Write 8'hA5 to reg 3 (we=8'h08), next cycle read addr 3 -> rd_data=8'hA5.
REQ-040 Same cycle we=8'h10, wd=8'h3C, read addr 4 -> 8'h3C with IRF_READ_BYPASS_EN, prior value without.
REQ-041 Read accepted, rd_ack=0 for 4 cycles while writing 8'hFF to that address -> rd_data stable, rd_rdy=0, rd_valid=1 throughout.
REQ-042 we=8'h06, wd=8'h77 -> regs 1 and 2 unchanged, err_multi=1 next cycle and stays 1 until rst_n low.
REQ-043 FULL with rd_ack=0, assert rst_n=0 one cycle -> rd_valid=0, rd_data=0, all regs 8'h00 after the edge.
